// File: rtl/spi2gpio_pkg.sv
// spi2gpio_pkg: shared register-bus constants and arbiter state encoding
package spi2gpio_pkg;
    localparam int         REG_ADDR_SZ   = 5;
    localparam logic [7:0] TIMEOUT_RDATA = 8'h00;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_e;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin grant; ptr is the last granted requester
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt
);
    assign gnt[0] = req[0] & (~req[1] | ptr);
    assign gnt[1] = req[1] & (~req[0] | ~ptr);
endmodule

// File: rtl/reg_bus_arbiter.sv
// reg_bus_arbiter: shares one register bus between two requesters, one access outstanding
module reg_bus_arbiter
    import spi2gpio_pkg::*;
#(
    parameter int ADDR_W      = REG_ADDR_SZ,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req0,
    input  logic              i_req1,
    input  logic              i_wr0,
    input  logic              i_wr1,
    input  logic [ADDR_W-1:0] i_addr0,
    input  logic [ADDR_W-1:0] i_addr1,
    input  logic [7:0]        i_wdata0,
    input  logic [7:0]        i_wdata1,
    output logic              o_ack0,
    output logic              o_ack1,
    output logic [7:0]        o_rdata,
    output logic              o_err,
    output logic              o_bus_rd_n,
    output logic              o_bus_wr_n,
    output logic [ADDR_W-1:0] o_bus_addr,
    output logic [7:0]        o_bus_wdata,
    input  logic [7:0]        i_bus_rdata,
    input  logic              i_bus_busy
);
    arb_state_e state, state_nxt;
    logic       last;
    logic       wr;
    logic [1:0] gnt;
    logic [7:0] cnt;
    logic       timeout;

    rr_arb2 u_rr_arb2 (.req({i_req1, i_req0}), .ptr(last), .gnt(gnt));

    assign timeout = cnt == 8'(TIMEOUT_CYC - 1);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = |gnt ? ISSUE : IDLE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    state_nxt = (!i_bus_busy || timeout) ? RESP : WAIT;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        o_bus_rd_n = !(state == ISSUE && !wr);
        o_bus_wr_n = !(state == ISSUE && wr);
        o_ack0     = state == RESP && !last;
        o_ack1     = state == RESP && last;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // last doubles as the winner id of the outstanding access
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            last        <= 1'b1;
            wr          <= 1'b0;
            o_bus_addr  <= '0;
            o_bus_wdata <= '0;
            o_rdata     <= '0;
            o_err       <= 1'b0;
            cnt         <= '0;
        end else begin
            if (state == IDLE && |gnt) begin
                last        <= gnt[1];
                wr          <= gnt[1] ? i_wr1 : i_wr0;
                o_bus_addr  <= gnt[1] ? i_addr1 : i_addr0;
                o_bus_wdata <= gnt[1] ? i_wdata1 : i_wdata0;
            end
            if (state == ISSUE) cnt <= '0;
            else if (state == WAIT && cnt != 8'hFF) cnt <= cnt + 8'd1;
            if (state == WAIT && !i_bus_busy) begin
                if (!wr) o_rdata <= i_bus_rdata;
                o_err <= 1'b0;
            end else if (state == WAIT && timeout) begin
                o_rdata <= TIMEOUT_RDATA;
                o_err   <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_reg_bus_arbiter.sv
// tb_reg_bus_arbiter: default and TIMEOUT_CYC=4 instances checked against a cycle-stamp transaction model
module tb_reg_bus_arbiter;
    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_req0 = 1'b0, i_req1 = 1'b0, i_wr0 = 1'b0, i_wr1 = 1'b0;
    logic [4:0] i_addr0 = '0, i_addr1 = '0;
    logic [7:0] i_wdata0 = '0, i_wdata1 = '0, i_bus_rdata = '0;
    logic       i_bus_busy = 1'b0;
    logic [1:0] ack0, ack1, err, rd_n, wr_n;
    logic [7:0] rdata [2];
    logic [4:0] baddr [2];
    logic [7:0] bwdata [2];

    int nchecks = 0, nerr = 0;
    bit chk_en = 1'b0;

    always #5 i_clk = ~i_clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        reg_bus_arbiter #(.ADDR_W(5), .TIMEOUT_CYC(g == 0 ? 255 : 4)) u_dut (
            .i_clk(i_clk), .i_rst_n(i_rst_n),
            .i_req0(i_req0), .i_req1(i_req1), .i_wr0(i_wr0), .i_wr1(i_wr1),
            .i_addr0(i_addr0), .i_addr1(i_addr1), .i_wdata0(i_wdata0), .i_wdata1(i_wdata1),
            .o_ack0(ack0[g]), .o_ack1(ack1[g]), .o_rdata(rdata[g]), .o_err(err[g]),
            .o_bus_rd_n(rd_n[g]), .o_bus_wr_n(wr_n[g]),
            .o_bus_addr(baddr[g]), .o_bus_wdata(bwdata[g]),
            .i_bus_rdata(i_bus_rdata), .i_bus_busy(i_bus_busy)
        );
    end

    // Model: each access is a record stamped with its issue cycle (lc) and ack cycle (ac, -1 until known)
    int         tmo [2] = '{255, 4};
    int         cyc = 0;
    bit         act [2] = '{0, 0};
    bit         lg [2] = '{1, 1};
    bit         lid [2] = '{0, 0};
    bit         lwr [2] = '{0, 0};
    int         lc [2] = '{-10, -10};
    int         ac [2] = '{-10, -10};
    logic [4:0] laddr [2] = '{5'd0, 5'd0};
    logic [7:0] lwd [2] = '{8'd0, 8'd0};
    logic [7:0] erd [2] = '{8'd0, 8'd0};
    bit         eerr [2] = '{0, 0};

    initial forever begin
        @(posedge i_clk or negedge i_rst_n);
        if (!i_rst_n) begin
            cyc = 0;
            for (int m = 0; m < 2; m++) begin
                act[m] = 0; lg[m] = 1; lid[m] = 0; lwr[m] = 0; lc[m] = -10; ac[m] = -10;
                laddr[m] = '0; lwd[m] = '0; erd[m] = '0; eerr[m] = 0;
            end
        end else begin
            cyc++;
            for (int m = 0; m < 2; m++) begin
                bit was_idle, w;
                was_idle = !act[m];
                if (act[m] && ac[m] == cyc - 1) act[m] = 0;
                else if (act[m] && ac[m] < 0 && cyc - 1 > lc[m]) begin
                    if (!i_bus_busy) begin
                        if (!lwr[m]) erd[m] = i_bus_rdata;
                        eerr[m] = 0;
                        ac[m] = cyc;
                    end else if (cyc - 1 - lc[m] >= tmo[m]) begin
                        erd[m] = 8'h00;
                        eerr[m] = 1;
                        ac[m] = cyc;
                    end
                end
                if (was_idle && (i_req0 || i_req1)) begin
                    w = (i_req0 && i_req1) ? !lg[m] : i_req1;
                    lg[m] = w; lid[m] = w;
                    lwr[m] = w ? i_wr1 : i_wr0;
                    laddr[m] = w ? i_addr1 : i_addr0;
                    lwd[m] = w ? i_wdata1 : i_wdata0;
                    act[m] = 1; lc[m] = cyc; ac[m] = -1;
                end
            end
        end
    end

    task automatic chk(input string nm, input int m, input logic [7:0] got, input logic [7:0] exp);
        nchecks++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s dut%0d t=%0t got %h expected %h", nm, m, $time, got, exp);
        end
    endtask

    always @(negedge i_clk) if (chk_en) for (int m = 0; m < 2; m++) begin
        chk("rd_n", m, 8'(rd_n[m]), 8'(!(act[m] && cyc == lc[m] && !lwr[m])));
        chk("wr_n", m, 8'(wr_n[m]), 8'(!(act[m] && cyc == lc[m] && lwr[m])));
        chk("ack0", m, 8'(ack0[m]), 8'(act[m] && ac[m] == cyc && !lid[m]));
        chk("ack1", m, 8'(ack1[m]), 8'(act[m] && ac[m] == cyc && lid[m]));
        chk("rdata", m, rdata[m], erd[m]);
        chk("err", m, 8'(err[m]), 8'(eerr[m]));
        chk("bus_addr", m, 8'(baddr[m]), 8'(laddr[m]));
        chk("bus_wdata", m, bwdata[m], lwd[m]);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic lit(input string nm, input int m, input logic [7:0] got, input logic [7:0] exp);
        chk({"lit_", nm}, m, got, exp);
    endtask

    initial begin
        tick(1);
        chk_en = 1'b1;
        @(negedge i_clk);
        lit("rst_strobes", 0, 8'({rd_n[0], wr_n[0]}), 8'h03);
        lit("rst_ack", 1, 8'({ack0[1], ack1[1]}), 8'h00);
        tick(1);
        i_rst_n = 1'b1;
        tick(1);
        // single read, busy low
        i_bus_rdata = 8'hA5; i_req0 = 1; i_wr0 = 0; i_addr0 = 5'h02;
        tick(1); i_req0 = 0;
        @(negedge i_clk); lit("read_rd_n", 0, 8'(rd_n[0]), 8'h00);
        tick(2);
        @(negedge i_clk);
        lit("read_ack0", 0, 8'(ack0[0]), 8'h01);
        lit("read_rdata", 0, rdata[0], 8'hA5);
        lit("read_err", 1, 8'(err[1]), 8'h00);
        tick(2);
        // fresh reset, then both request continuously
        i_rst_n = 0; tick(1); i_rst_n = 1; tick(1);
        i_req0 = 1; i_wr0 = 1; i_addr0 = 5'h01; i_wdata0 = 8'h11;
        i_req1 = 1; i_wr1 = 1; i_addr1 = 5'h09; i_wdata1 = 8'h22;
        for (int i = 0; i < 4; i++) begin
            tick(i == 0 ? 3 : 4);
            @(negedge i_clk);
            lit("rr_ack0", 0, 8'(ack0[0]), 8'(i % 2 == 0));
            lit("rr_ack1", 0, 8'(ack1[0]), 8'(i % 2 == 1));
            lit("rr_wdata", 0, bwdata[0], (i % 2 == 0) ? 8'h11 : 8'h22);
        end
        tick(1); i_req0 = 0; i_req1 = 0; i_wr0 = 0; i_wr1 = 0;
        tick(2);
        // ten-cycle stall
        i_bus_rdata = 8'h3C; i_bus_busy = 1; i_req0 = 1; i_addr0 = 5'h04;
        tick(1); i_req0 = 0;
        tick(11); i_bus_busy = 0;
        @(negedge i_clk); lit("stall_noack", 0, 8'(ack0[0]), 8'h00);
        tick(1);
        @(negedge i_clk);
        lit("stall_ack0", 0, 8'(ack0[0]), 8'h01);
        lit("stall_rdata", 0, rdata[0], 8'h3C);
        tick(2);
        // stuck busy: instance 1 times out after 4, instance 0 after 255
        i_bus_busy = 1; i_req1 = 1; i_wr1 = 0; i_addr1 = 5'h07;
        tick(1); i_req1 = 0;
        tick(5);
        @(negedge i_clk);
        lit("tmo4_ack1", 1, 8'(ack1[1]), 8'h01);
        lit("tmo4_err", 1, 8'(err[1]), 8'h01);
        lit("tmo4_rdata", 1, rdata[1], 8'h00);
        tick(251);
        @(negedge i_clk);
        lit("tmo255_ack1", 0, 8'(ack1[0]), 8'h01);
        lit("tmo255_err", 0, 8'(err[0]), 8'h01);
        tick(1); i_bus_busy = 0;
        i_bus_rdata = 8'h5A; i_req0 = 1; i_addr0 = 5'h03;
        tick(1); i_req0 = 0;
        tick(2);
        @(negedge i_clk);
        lit("after_tmo_err", 1, 8'(err[1]), 8'h00);
        lit("after_tmo_rdata", 1, rdata[1], 8'h5A);
        tick(2);
        // reset while waiting
        i_bus_busy = 1; i_req0 = 1; i_addr0 = 5'h06;
        tick(1); i_req0 = 0;
        tick(2); i_rst_n = 0;
        @(negedge i_clk);
        lit("rstwait_strobes", 0, 8'({rd_n[0], wr_n[0]}), 8'h03);
        lit("rstwait_ack", 0, 8'({ack0[0], ack1[0]}), 8'h00);
        tick(1); i_rst_n = 1; i_bus_busy = 0;
        tick(1);
        i_bus_rdata = 8'h77; i_req1 = 1; i_addr1 = 5'h0B;
        tick(1); i_req1 = 0;
        tick(2);
        @(negedge i_clk);
        lit("rstwait_ack1", 0, 8'(ack1[0]), 8'h01);
        lit("rstwait_rdata", 0, rdata[0], 8'h77);
        tick(2);
        // req1 pulse during WAIT is ignored
        i_bus_busy = 1; i_bus_rdata = 8'h99; i_req0 = 1; i_addr0 = 5'h08;
        tick(1); i_req0 = 0;
        tick(2); i_req1 = 1;
        tick(1); i_req1 = 0;
        tick(2); i_bus_busy = 0;
        tick(1);
        @(negedge i_clk);
        lit("pulse_ack0", 0, 8'(ack0[0]), 8'h01);
        lit("pulse_noack1", 0, 8'(ack1[0]), 8'h00);
        tick(3);
        // req1 dropped in ISSUE still completes
        i_req1 = 1; i_wr1 = 1; i_addr1 = 5'h03; i_wdata1 = 8'h5C;
        tick(1); i_req1 = 0;
        @(negedge i_clk);
        lit("drop_wr_n", 0, 8'(wr_n[0]), 8'h00);
        lit("drop_wdata", 0, bwdata[0], 8'h5C);
        tick(2);
        @(negedge i_clk);
        lit("drop_ack1", 0, 8'(ack1[0]), 8'h01);
        tick(3);
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end
endmodule
